gpr_scoreboard: RTL and testbench
=================================

Name: gpr_scoreboard

Overview:
- In-order RAW-hazard scheduler for the decode stage.
- Keeps an ordered in-flight queue of destination registers for every decoded instruction that has not yet written back.
- Compares the decoder's rs1/rs2 (with their valid flags) against that queue and generates the decode-enable and source-block signals that stall the ID/EX register.
- Flush on redirect and retire on writeback shrink the queue.

Parameters:
DEPTH, 4, max in-flight instructions tracked (2..8)
CNT_W, $clog2(DEPTH+1), width of count and flush_keep

Ports:
clk  in  1  sole clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
rs1  in  5  decoder source 1 index
rs1_valid  in  1  rs1 is read by current instruction
rs2  in  5  decoder source 2 index
rs2_valid  in  1  rs2 is read by current instruction
issue_valid  in  1  decoder pushes an instruction into ID/EX this cycle
issue_rd  in  5  destination of pushed instruction
issue_dest_wen  in  1  pushed instruction writes GPR
retire_valid  in  1  oldest in-flight instruction completes writeback this cycle
flush_valid  in  1  redirect; discard younger in-flight entries
flush_keep  in  CNT_W  number of oldest entries (pre-cycle order) that survive flush
decode_enable  out  1  decoder may advance
src_block_flag  out  1  RAW hazard on current sources
count  out  CNT_W  in-flight entries
full  out  1  count==DEPTH
empty  out  1  count==0
err  out  1  sticky protocol error

Behaviour:
- Reset is async: rst high immediately clears the queue and err. Resulting output values: count=0, empty=1, full=0, err=0, src_block_flag=0, decode_enable=1.
- Storage: circular buffer of DEPTH entries {rd[4:0], wen}.
  - Index 0 = oldest = head.
  - Head/tail pointers wrap modulo DEPTH.
  - count is a registered counter, never derived from pointer difference alone.
- Hazard (combinational from registered state and current rs inputs):
  - An entry matches rsX when: valid, wen=1, rd!=0, rd==rsX, and rsX_valid=1.
  - Head is excluded when retire_valid=1 in the same cycle, because the regfile is write-through.
  - src_block_flag = any match on rs1 or rs2. Register x0 never blocks.
- decode_enable = ~src_block_flag & ~full. It is 0 whenever full, even when retire_valid is high (no same-cycle refill).
- Issue:
  - Push {issue_rd, issue_dest_wen} at tail when issue_valid=1, count<DEPTH, and flush_valid=0.
  - Entries with wen=0 are still pushed, to keep ordering with retire.
  - issue_valid while full sets err; the push is dropped.
- Retire:
  - Pop head when retire_valid=1 and count>0.
  - retire_valid with count==0 sets err; no state change.
- Simultaneous issue+retire (no flush): count unchanged, head and tail both advance.
- Flush (flush_valid=1):
  - keep = min(flush_keep, count), computed on pre-cycle count.
  - Tail is set to head+keep; entries beyond are invalidated.
  - If retire_valid also =1 and keep>0, head advances and new count = keep-1.
  - If retire_valid=1 and keep=0: new count = 0 and err is set.
  - issue_valid in the flush cycle is always dropped, without error.
- Latency:
  - Effect of push/pop/flush on hazard detection is visible from the next cycle.
  - Hazard output responds to rs inputs within the same cycle.
- err is sticky until rst.
- All outputs are glitch-tolerant combinational functions of registered state plus the current inputs listed above. There are no other registered outputs.

Test Plan:
- Reset then idle, rs1=5 rs1_valid=1 -> decode_enable=1, src_block_flag=0, count=0, empty=1.
- Issue rd=5 wen=1; next cycle rs1=5 valid -> src_block_flag=1, decode_enable=0. Assert retire_valid same cycle -> src_block_flag=0; next cycle count=0.
- Issue rd=0 wen=1, then rs2=0 rs2_valid=1 -> no block. Issue rd=7 wen=0, then rs1=7 -> no block. count=2.
- Issue 4 entries (DEPTH=4) -> full=1, decode_enable=0. Extra issue_valid -> err=1, count stays 4. Issue+retire same cycle when count=3 -> count stays 3, pointers wrap correctly over 10 cycles.
- count=4 with rds {1,2,3,4}, flush_valid with flush_keep=2 -> count=2, rs1=3 no longer blocks, rs1=2 blocks. Same scenario with retire_valid=1 -> count=1, only rd=2 remains. flush_keep=7 -> all 4 kept.
- Issue rd=9 wen=1 then assert rst mid-stream -> immediately count=0, src_block_flag=0 for rs1=9, err cleared. Retire on empty -> err=1 and stays 1.

Source files
------------

// File: rtl/gpr_scoreboard_if.sv
// Decode-stage scoreboard bus: decoder sources, issue/retire/flush controls
// and the scoreboard's stall/status outputs.
interface gpr_scoreboard_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);
  logic [4:0]       rs1;
  logic             rs1_valid;
  logic [4:0]       rs2;
  logic             rs2_valid;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_dest_wen;
  logic             retire_valid;
  logic             flush_valid;
  logic [CNT_W-1:0] flush_keep;
  logic             decode_enable;
  logic             src_block_flag;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output rs1, rs1_valid, rs2, rs2_valid,
    output issue_valid, issue_rd, issue_dest_wen,
    output retire_valid, flush_valid, flush_keep,
    input  decode_enable, src_block_flag, count, full, empty, err
  );

  modport slave (
    input  rs1, rs1_valid, rs2, rs2_valid,
    input  issue_valid, issue_rd, issue_dest_wen,
    input  retire_valid, flush_valid, flush_keep,
    output decode_enable, src_block_flag, count, full, empty, err
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// In-order RAW-hazard scoreboard: circular queue of in-flight destination
// registers, compared against decoder sources to stall the ID/EX register.
module gpr_scoreboard #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  gpr_scoreboard_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = CNT_W + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [4:0]       rd_q [DEPTH];
  logic [DEPTH-1:0] wen_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             push;
  logic [CNT_W-1:0] keep;
  logic             full_w;
  logic             hit1, hit2;
  logic [SW-1:0]    off;
  logic             live;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [CNT_W-1:0] inc);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(inc);
    if (sum >= DEPTH_S) sum = sum - DEPTH_S;
    return sum[PTR_W-1:0];
  endfunction

  assign full_w = (count_q == CNT_W'(DEPTH));

  // Hazard match: entry is live when its age offset from head is below count;
  // the head is skipped on a retiring cycle since the regfile writes through.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    live = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = SW'(i) + DEPTH_S - SW'(head_q);
      if (off >= DEPTH_S) off = off - DEPTH_S;
      live = (off < SW'(count_q)) && !(bus.retire_valid && (off == '0));
      if (live && wen_q[i] && (rd_q[i] != 5'd0)) begin
        if (bus.rs1_valid && (rd_q[i] == bus.rs1)) hit1 = 1'b1;
        if (bus.rs2_valid && (rd_q[i] == bus.rs2)) hit2 = 1'b1;
      end
    end
  end

  assign bus.src_block_flag = hit1 | hit2;
  assign bus.decode_enable  = ~(hit1 | hit2) & ~full_w;
  assign bus.count          = count_q;
  assign bus.full           = full_w;
  assign bus.empty          = (count_q == '0);
  assign bus.err            = err_q;

  // Next-state for pointers, count and sticky error; flush overrides issue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    push    = 1'b0;
    keep    = (bus.flush_keep < count_q) ? bus.flush_keep : count_q;
    if (bus.flush_valid) begin
      tail_d = wrap_add(head_q, keep);
      if (bus.retire_valid) begin
        if (keep != '0) begin
          head_d  = wrap_add(head_q, CNT_W'(1));
          count_d = keep - CNT_W'(1);
        end else begin
          count_d = '0;
          err_d   = 1'b1;
        end
      end else begin
        count_d = keep;
      end
    end else begin
      push = bus.issue_valid && !full_w;
      if (bus.issue_valid && full_w) err_d = 1'b1;
      if (bus.retire_valid && (count_q == '0)) err_d = 1'b1;
      if (push) tail_d = wrap_add(tail_q, CNT_W'(1));
      if (bus.retire_valid && (count_q != '0)) begin
        head_d = wrap_add(head_q, CNT_W'(1));
        if (!push) count_d = count_q - CNT_W'(1);
      end else if (push) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State registers and queue storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      wen_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        rd_q[tail_q]  <= bus.issue_rd;
        wen_q[tail_q] <= bus.issue_dest_wen;
      end
    end
  end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed self-checking bench for gpr_scoreboard (DEPTH=4).
module tb_gpr_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpr_scoreboard_if #(.DEPTH(4)) bus ();
  gpr_scoreboard #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic clr();
    bus.rs1 = '0; bus.rs1_valid = 1'b0; bus.rs2 = '0; bus.rs2_valid = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_dest_wen = 1'b0;
    bus.retire_valid = 1'b0; bus.flush_valid = 1'b0; bus.flush_keep = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen);
    clr();
    bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_dest_wen = wen;
    cyc();
    clr();
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) issue(5'(i), 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    bus.rs1 = 5'd5; bus.rs1_valid = 1'b1; #1;
    checks++; if (bus.decode_enable !== 1'b1) begin errors++; $display("FAIL reset_de got %b exp 1", bus.decode_enable); end
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL reset_blk got %b exp 0", bus.src_block_flag); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
  endtask

  task automatic test_raw_retire();
    do_reset();
    issue(5'd5, 1'b1);
    bus.rs1 = 5'd5; bus.rs1_valid = 1'b1; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL raw_blk got %b exp 1", bus.src_block_flag); end
    checks++; if (bus.decode_enable !== 1'b0) begin errors++; $display("FAIL raw_de got %b exp 0", bus.decode_enable); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL raw_count got %0d exp 1", bus.count); end
    bus.retire_valid = 1'b1; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL wthru_blk got %b exp 0", bus.src_block_flag); end
    checks++; if (bus.decode_enable !== 1'b1) begin errors++; $display("FAIL wthru_de got %b exp 1", bus.decode_enable); end
    cyc(); clr(); #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL retire_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL retire_empty got %b exp 1", bus.empty); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL retire_err got %b exp 0", bus.err); end
  endtask

  task automatic test_x0_nowen();
    do_reset();
    issue(5'd0, 1'b1);
    bus.rs2 = 5'd0; bus.rs2_valid = 1'b1; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL x0_blk got %b exp 0", bus.src_block_flag); end
    issue(5'd7, 1'b0);
    bus.rs1 = 5'd7; bus.rs1_valid = 1'b1; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL nowen_blk got %b exp 0", bus.src_block_flag); end
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL nowen_count got %0d exp 2", bus.count); end
    issue(5'd3, 1'b1);
    bus.rs1 = 5'd3; bus.rs1_valid = 1'b0; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL rsvalid_blk got %b exp 0", bus.src_block_flag); end
    bus.rs2 = 5'd3; bus.rs2_valid = 1'b1; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL rs2_blk got %b exp 1", bus.src_block_flag); end
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL x0_count got %0d exp 3", bus.count); end
  endtask

  task automatic test_full_err_wrap();
    do_reset();
    fill4();
    bus.rs1 = 5'd20; bus.rs1_valid = 1'b1; bus.retire_valid = 1'b1; #1;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full got %b exp 1", bus.full); end
    checks++; if (bus.decode_enable !== 1'b0) begin errors++; $display("FAIL full_de got %b exp 0", bus.decode_enable); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.count); end
    clr();
    issue(5'd9, 1'b1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", bus.err); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", bus.count); end
    bus.retire_valid = 1'b1; cyc(); clr(); #1;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL pop_count got %0d exp 3", bus.count); end
    for (int k = 0; k < 10; k++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(10 + k); bus.issue_dest_wen = 1'b1;
      bus.retire_valid = 1'b1;
      cyc(); clr(); #1;
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 3", k, bus.count); end
    end
    bus.rs1_valid = 1'b1;
    bus.rs1 = 5'd17; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL wrap_17 got %b exp 1", bus.src_block_flag); end
    bus.rs1 = 5'd16; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL wrap_16 got %b exp 0", bus.src_block_flag); end
    bus.rs1 = 5'd19; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL wrap_19 got %b exp 1", bus.src_block_flag); end
    bus.retire_valid = 1'b1; bus.rs1 = 5'd17; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL wrap_head_excl got %b exp 0", bus.src_block_flag); end
    bus.rs1 = 5'd18; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL wrap_18 got %b exp 1", bus.src_block_flag); end
    clr();
  endtask

  task automatic test_flush();
    do_reset();
    fill4();
    bus.flush_valid = 1'b1; bus.flush_keep = 3'd2; cyc(); clr();
    bus.rs1_valid = 1'b1; bus.rs1 = 5'd3; #1;
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL fl2_count got %0d exp 2", bus.count); end
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL fl2_rs3 got %b exp 0", bus.src_block_flag); end
    bus.rs1 = 5'd2; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL fl2_rs2 got %b exp 1", bus.src_block_flag); end
    issue(5'd6, 1'b1);
    bus.rs1 = 5'd6; bus.rs1_valid = 1'b1; #1;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL fl2_refill_count got %0d exp 3", bus.count); end
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL fl2_refill_blk got %b exp 1", bus.src_block_flag); end

    do_reset();
    fill4();
    bus.flush_valid = 1'b1; bus.flush_keep = 3'd2; bus.retire_valid = 1'b1; cyc(); clr();
    bus.rs1_valid = 1'b1; bus.rs1 = 5'd2; #1;
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL flr_count got %0d exp 1", bus.count); end
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL flr_rs2 got %b exp 1", bus.src_block_flag); end
    bus.rs1 = 5'd1; #1;
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL flr_rs1 got %b exp 0", bus.src_block_flag); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL flr_err got %b exp 0", bus.err); end

    do_reset();
    fill4();
    bus.flush_valid = 1'b1; bus.flush_keep = 3'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_dest_wen = 1'b1;
    cyc(); clr();
    bus.rs1_valid = 1'b1; bus.rs1 = 5'd4; #1;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fl7_count got %0d exp 4", bus.count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL fl7_err got %b exp 0", bus.err); end
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL fl7_rs4 got %b exp 1", bus.src_block_flag); end
    clr();
    bus.flush_valid = 1'b1; bus.flush_keep = 3'd0; bus.retire_valid = 1'b1; cyc(); clr(); #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL fl0r_count got %0d exp 0", bus.count); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL fl0r_err got %b exp 1", bus.err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.retire_valid = 1'b1; cyc(); clr(); #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL empty_retire_err got %b exp 1", bus.err); end
    issue(5'd9, 1'b1);
    bus.rs1 = 5'd9; bus.rs1_valid = 1'b1; #1;
    checks++; if (bus.src_block_flag !== 1'b1) begin errors++; $display("FAIL pre_rst_blk got %b exp 1", bus.src_block_flag); end
    rst = 1'b1; #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL async_count got %0d exp 0", bus.count); end
    checks++; if (bus.src_block_flag !== 1'b0) begin errors++; $display("FAIL async_blk got %b exp 0", bus.src_block_flag); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL async_err got %b exp 0", bus.err); end
    rst = 1'b0; clr();
    bus.retire_valid = 1'b1; cyc(); clr(); #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", bus.err); end
    cyc(); cyc(); cyc();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
  endtask

  initial begin
    clr();
    test_reset();
    test_raw_retire();
    test_x0_nowen();
    test_full_err_wrap();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
